// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word sequential adder: word width and FSM state encoding.
package mwadd_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } mwadd_state_t;

endpackage

// File: rtl/multiword_adder_seq_adder.sv
// The existing 32-bit ripple-carry adder that the multi-word sequencer drives one word per cycle.
module mwadd_ripple_adder32
   import mwadd_pkg::*;
(
   output logic [WORD_W-1:0] sum,
   output logic              cout,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin
);

   // Explicit bit-serial carry chain, mirroring the ripple structure of the original adder.
   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < WORD_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-precision adder: walks WORDS 32-bit words LSW first through one shared 32-bit adder,
// chaining the registered carry between words, with valid/ready handshakes on both sides.
module multiword_adder_seq
   import mwadd_pkg::*;
#(
   parameter  int WORDS = 2,
   localparam int W     = WORD_W * WORDS
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   mwadd_state_t state, state_next;

   logic [WORDS-1:0][WORD_W-1:0] a_reg;
   logic [WORDS-1:0][WORD_W-1:0] b_reg;
   logic [WORDS-1:0][WORD_W-1:0] sum_reg;
   logic [IDX_W-1:0]             idx;
   logic                         carry;
   logic                         cout_reg;
   logic                         overflow_reg;

   logic [WORD_W-1:0] word_sum;
   logic              word_cout;
   logic              last_word;

   assign last_word = (idx == IDX_W'(WORDS - 1));

   mwadd_ripple_adder32 u_adder (
      word_sum,
      word_cout,
      a_reg[idx],
      b_reg[idx],
      carry
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = ADD;
         ADD:     if (last_word) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result outputs only change on ADD writes, so they keep the last result through IDLE
   // even after the next operands have been captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         sum_reg      <= '0;
         idx          <= '0;
         carry        <= 1'b0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  idx   <= '0;
               end
            end
            ADD: begin
               sum_reg[idx] <= word_sum;
               carry        <= word_cout;
               if (last_word) begin
                  cout_reg     <= word_cout;
                  overflow_reg <= (a_reg[WORDS-1][WORD_W-1] == b_reg[WORDS-1][WORD_W-1]) &&
                                  (word_sum[WORD_W-1] != a_reg[WORDS-1][WORD_W-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq: directed cases on WORDS=2, then randomized
// traffic on WORDS=1, 2 and 4 instances against an arithmetic reference model.
module tb_multiword_adder_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] a_bus;
   logic [127:0] b_bus;
   logic         cin;
   logic [2:0]   in_valid_v;
   logic [2:0]   out_ready_v;
   wire  [2:0]   in_ready_v;
   wire  [2:0]   out_valid_v;
   wire  [2:0]   cout_v;
   wire  [2:0]   overflow_v;
   wire  [31:0]  sum1;
   wire  [63:0]  sum2;
   wire  [127:0] sum4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiword_adder_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_bus[31:0]), .b(b_bus[31:0]), .cin(cin),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .sum(sum1), .cout(cout_v[0]), .overflow(overflow_v[0])
   );

   multiword_adder_seq #(.WORDS(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_bus[63:0]), .b(b_bus[63:0]), .cin(cin),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .sum(sum2), .cout(cout_v[1]), .overflow(overflow_v[1])
   );

   multiword_adder_seq #(.WORDS(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a_bus), .b(b_bus), .cin(cin),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
      .sum(sum4), .cout(cout_v[2]), .overflow(overflow_v[2])
   );

   function automatic logic [127:0] sumOf(input int sel);
      case (sel)
         0:       return {96'd0, sum1};
         1:       return {64'd0, sum2};
         default: return sum4;
      endcase
   endfunction

   // Reference: plain wide arithmetic truncated to the operand width.
   function automatic void model(input int words, input logic [127:0] av, input logic [127:0] bv,
                                 input logic cv, output logic [127:0] s, output logic co,
                                 output logic ov);
      int          w;
      logic [128:0] mask;
      logic [128:0] full;
      w    = 32 * words;
      mask = (129'd1 << w) - 129'd1;
      full = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {128'd0, cv};
      s    = full[127:0] & mask[127:0];
      co   = full[w];
      ov   = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Offers an operand set on instance sel; returns at the negedge after the accept edge.
   task automatic applyStimulus(input int sel, input logic [127:0] av, input logic [127:0] bv,
                                input logic cv);
      int guard;
      guard = 0;
      a_bus = av;
      b_bus = bv;
      cin   = cv;
      in_valid_v[sel] = 1'b1;
      while (!in_ready_v[sel] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         checkOutput("accept_timeout", 128'd0, 128'd1);
         in_valid_v[sel] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid_v[sel] = 1'b0;
      a_bus = {$urandom, $urandom, $urandom, $urandom};
      b_bus = {$urandom, $urandom, $urandom, $urandom};
      cin   = 1'($urandom);
   endtask

   // Counts edges from the accept edge (as 1) until out_valid is seen.
   task automatic waitResult(input int sel, output int cnt);
      cnt = 1;
      while (!out_valid_v[sel] && cnt < 60) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      if (!out_valid_v[sel]) checkOutput("result_timeout", 128'd0, 128'd1);
   endtask

   task automatic checkResult(input int sel, input int words, input string tag,
                              input logic [127:0] av, input logic [127:0] bv, input logic cv);
      logic [127:0] es;
      logic         ec;
      logic         eo;
      model(words, av, bv, cv, es, ec, eo);
      checkOutput({tag, "_sum"}, sumOf(sel), es);
      checkOutput({tag, "_cout"}, {127'd0, cout_v[sel]}, {127'd0, ec});
      checkOutput({tag, "_ovf"}, {127'd0, overflow_v[sel]}, {127'd0, eo});
   endtask

   task automatic drainResult(input int sel);
      out_ready_v[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_v[sel] = 1'b0;
      checkOutput("valid_drop", {127'd0, out_valid_v[sel]}, 128'd0);
   endtask

   initial begin
      int           lat;
      int           words;
      int           gap;
      logic [127:0] ra;
      logic [127:0] rb;
      logic         rc;
      logic [127:0] es;
      logic         ec;
      logic         eo;
      logic         seen_valid;

      rst         = 1'b1;
      a_bus       = '0;
      b_bus       = '0;
      cin         = 1'b0;
      in_valid_v  = 3'b010;
      out_ready_v = 3'b000;

      // Reset held for two cycles with in_valid asserted.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("rst_in_ready", {127'd0, in_ready_v[1]}, 128'd0);
         checkOutput("rst_out_valid", {127'd0, out_valid_v[1]}, 128'd0);
         checkOutput("rst_sum", sumOf(1), 128'd0);
         checkOutput("rst_cout", {127'd0, cout_v[1]}, 128'd0);
      end
      rst        = 1'b0;
      in_valid_v = 3'b000;
      #1;
      checkOutput("post_rst_in_ready", {127'd0, in_ready_v[1]}, 128'd1);
      @(negedge clk);

      // Carry across the word boundary plus latency.
      applyStimulus(1, 128'h0000_0000_FFFF_FFFF, 128'h1, 1'b0);
      waitResult(1, lat);
      checkOutput("latency_w2", lat, 3);
      checkOutput("carry_word_sum", sumOf(1), 128'h0000_0001_0000_0000);
      checkResult(1, 2, "carry_word", 128'h0000_0000_FFFF_FFFF, 128'h1, 1'b0);
      drainResult(1);

      applyStimulus(1, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1);
      waitResult(1, lat);
      checkOutput("wrap_sum", sumOf(1), 128'd0);
      checkOutput("wrap_cout", {127'd0, cout_v[1]}, 128'd1);
      checkResult(1, 2, "wrap", 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1);
      drainResult(1);

      applyStimulus(1, 128'h7FFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
      waitResult(1, lat);
      checkOutput("ovf_flag", {127'd0, overflow_v[1]}, 128'd1);
      checkResult(1, 2, "ovf", 128'h7FFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
      drainResult(1);

      // Backpressure: result must hold and a competing request must be refused.
      ra = 128'h1234_5678_9ABC_DEF0;
      rb = 128'hFEDC_BA98_7654_3210;
      applyStimulus(1, ra, rb, 1'b1);
      waitResult(1, lat);
      model(2, ra, rb, 1'b1, es, ec, eo);
      a_bus = 128'h5;
      b_bus = 128'h6;
      cin   = 1'b0;
      in_valid_v[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("bp_valid", {127'd0, out_valid_v[1]}, 128'd1);
         checkOutput("bp_in_ready", {127'd0, in_ready_v[1]}, 128'd0);
         checkOutput("bp_sum", sumOf(1), es);
         checkOutput("bp_cout", {127'd0, cout_v[1]}, {127'd0, ec});
      end
      in_valid_v[1] = 1'b0;
      drainResult(1);
      applyStimulus(1, 128'h5, 128'h6, 1'b0);
      waitResult(1, lat);
      checkResult(1, 2, "bp_second", 128'h5, 128'h6, 1'b0);
      drainResult(1);

      // Reset in the second ADD cycle aborts the operation.
      applyStimulus(1, 128'hAAAA_AAAA_5555_5555, 128'h1111_1111_2222_2222, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abort_idle", {127'd0, in_ready_v[1]}, 128'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid_v[1]) seen_valid = 1'b1;
      end
      checkOutput("abort_no_valid", {127'd0, seen_valid}, 128'd0);
      applyStimulus(1, 128'd5, 128'd7, 1'b0);
      waitResult(1, lat);
      checkOutput("after_abort_sum", sumOf(1), 128'd12);
      drainResult(1);

      // Randomized traffic on each width.
      for (int sel = 0; sel < 3; sel++) begin
         words = 1 << sel;
         for (int n = 0; n < 67; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom);
            case ($urandom_range(0, 5))
               0: begin ra = '1; rb = '0; end
               1: begin ra = {1'b0, {127{1'b1}}} >> (128 - 32 * words); rb = 128'd1; end
               default: ;
            endcase
            applyStimulus(sel, ra, rb, rc);
            waitResult(sel, lat);
            checkOutput("rand_latency", lat, words + 1);
            checkResult(sel, words, "rand", ra, rb, rc);
            model(words, ra, rb, rc, es, ec, eo);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               @(negedge clk);
               checkOutput("rand_hold", sumOf(sel), es);
            end
            drainResult(sel);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
